// File: rtl/mux_ent_pkg.sv
// Shared types, defaults and parameter helpers for the RTC input-port multiplexer.
package mux_ent_pkg;

  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_N     = 13;
  localparam int unsigned DEF_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } mux_ent_state_t;

  // Smallest select width able to address n channels.
  function automatic int unsigned min_sel_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_ent_scan_if.sv
// Processor read / scan handshake bundle between the mux and its consumer.
interface mux_ent_scan_if
  import mux_ent_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SEL_W = DEF_SEL_W
) ();

  logic [SEL_W-1:0] sel;
  logic             r_s;
  logic [N*W-1:0]   ch;
  logic             scan_start;
  logic             ready;
  logic [W-1:0]     sal;
  logic [SEL_W-1:0] sal_idx;
  logic             sal_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output sel, r_s, ch, scan_start, ready,
    input  sal, sal_idx, sal_valid, busy, done, err
  );

  modport slave (
    input  sel, r_s, ch, scan_start, ready,
    output sal, sal_idx, sal_valid, busy, done, err
  );

endinterface

// File: rtl/mux_ent_sel.sv
// Combinational N:1 channel selector; yields zero and a cleared flag for out-of-range indices.
module mux_ent_sel
  import mux_ent_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic [N*W-1:0]   ch,
  input  logic [SEL_W-1:0] idx,
  output logic [W-1:0]     data_c,
  output logic             in_range_c
);

  always_comb begin
    data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx == SEL_W'(i)) data_c = ch[i*W +: W];
    end
  end

  assign in_range_c = (32'(idx) < 32'(N));

endmodule

// File: rtl/mux_ent_scan.sv
// Registered input-port mux with direct reads and an autonomous valid/ready channel sweep.
module mux_ent_scan
  import mux_ent_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic         clk,
  input  logic         reset,
  mux_ent_scan_if.slave bus
);

  if (N < 2 || SEL_W < min_sel_w(N)) begin : g_param_check
    $error("mux_ent_scan: N must be >= 2 and 2**SEL_W must cover N");
  end

  mux_ent_state_t   state, state_d;
  logic [SEL_W-1:0] idx, idx_d;
  logic [W-1:0]     sal_q, sal_d;
  logic [SEL_W-1:0] sal_idx_q, sal_idx_d;
  logic             sal_valid_q, sal_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] idx_inc;
  logic [W-1:0]     pick_data;
  logic             pick_ok;
  logic             accept;
  logic             last;

  assign idx_inc = idx + SEL_W'(1);
  assign accept  = sal_valid_q & bus.ready;
  assign last    = (idx == SEL_W'(N - 1));

  // One selector serves both paths: scan index (advanced on accept) or the direct select.
  always_comb begin
    pick_idx = bus.sel;
    if (state == SCAN)        pick_idx = accept ? idx_inc : idx;
    else if (bus.scan_start)  pick_idx = '0;
  end

  mux_ent_sel #(.W(W), .N(N), .SEL_W(SEL_W)) u_sel (
    .ch         (bus.ch),
    .idx        (pick_idx),
    .data_c     (pick_data),
    .in_range_c (pick_ok)
  );

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    sal_d       = sal_q;
    sal_idx_d   = sal_idx_q;
    sal_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.scan_start) begin
          state_d     = SCAN;
          idx_d       = '0;
          sal_d       = pick_data;
          sal_idx_d   = '0;
          sal_valid_d = 1'b1;
          busy_d      = 1'b1;
          err_d       = bus.r_s;
        end else if (bus.r_s) begin
          sal_d       = pick_data;
          sal_idx_d   = bus.sel;
          sal_valid_d = 1'b1;
          err_d       = ~pick_ok;
        end
      end
      SCAN: begin
        err_d = bus.r_s | bus.scan_start;
        if (accept && last) begin
          state_d = DONE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          // Unaccepted beats re-sample the same channel every cycle.
          idx_d       = pick_idx;
          sal_d       = pick_data;
          sal_idx_d   = pick_idx;
          sal_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = bus.r_s | bus.scan_start;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      sal_q       <= '0;
      sal_idx_q   <= '0;
      sal_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      sal_q       <= sal_d;
      sal_idx_q   <= sal_idx_d;
      sal_valid_q <= sal_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.sal       = sal_q;
  assign bus.sal_idx   = sal_idx_q;
  assign bus.sal_valid = sal_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/mux_ent_scan.md
# mux_ent_scan

Parametrised, registered input-port multiplexer for the RTC controller's processor read path. Selects one of `N` `W`-bit channels on a processor read strobe and registers it for the input port. Adds an autonomous scan mode that walks all channels in order under a valid/ready handshake, so a consumer can snapshot every RTC register in one sweep. Out-of-range selects produce a defined zero plus an error pulse, never X.

## Interface
Parameters:
- `W`, 8: channel and output data width.
- `N`, 13: channel count, ≥ 2.
- `SEL_W`, 4: select width; must satisfy 2^`SEL_W` ≥ `N`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sel`  in  `SEL_W`: channel index for a direct read.
- `r_s`  in  1: direct read strobe, sampled each cycle.
- `ch`  in  `N*W`: flattened channels; channel i is bits [i*W +: W].
- `scan_start`  in  1: one-cycle pulse starting a full sweep.
- `ready`  in  1: consumer accepts the scan beat in this cycle.
- `sal`  out  `W`: registered output data.
- `sal_idx`  out  `SEL_W`: channel index of the current `sal`.
- `sal_valid`  out  1: `sal` is valid.
- `busy`  out  1: a scan is in progress.
- `done`  out  1: one-cycle pulse after the last scan beat is accepted.
- `err`  out  1: one-cycle pulse on an out-of-range select or a rejected request.

## Operation
- FSM states: `IDLE`, `SCAN`, `DONE`.
- `IDLE`, `r_s`=1, `sel` < `N`:
  - next cycle `sal` = ch[`sel`], `sal_idx` = `sel`, `sal_valid` = 1 for one cycle.
  - No `ready` is required.
- `IDLE`, `r_s`=1, `sel` ≥ `N`: next cycle `sal` = 0, `sal_idx` = `sel`, `sal_valid` = 1, `err` = 1, each for one cycle.
- `IDLE`, `scan_start`=1: go to `SCAN`, index = 0. `scan_start` has priority over a simultaneous `r_s`; that `r_s` is dropped with `err` = 1.
- `SCAN`:
  - `sal` = ch[index], `sal_idx` = index, `sal_valid` = 1, `busy` = 1.
  - `sal` is re-sampled every cycle while the beat is not accepted.
  - On `sal_valid` & `ready`: if index = `N`-1, go to `DONE`; otherwise index + 1.
- `SCAN`, `r_s`=1 or `scan_start`=1: request ignored, `err` = 1 for one cycle, scan is unaffected.
- `DONE`: `done` = 1, `sal_valid` = 0, `busy` = 0; return to `IDLE` next cycle. An `r_s` arriving in `DONE` is dropped with `err` = 1.
- `sal` and `sal_idx` hold their last value whenever `sal_valid` = 0.

## Timing
- Reset (synchronous, active-high): all outputs = 0, state = `IDLE`, index = 0.
- Reset during `SCAN` aborts the sweep with no `done`.
- Direct-read latency: strobe at cycle t gives data and `sal_valid` at t+1.
- Back-to-back `r_s` gives one beat per cycle.
- Scan timing:
  - `scan_start` at t gives the first beat (channel 0) at t+1.
  - With `ready` held at 1, a sweep takes `N` beat cycles.
  - `done` is asserted at t+`N`+1; `busy` falls in that same cycle.
- `ready` = 0 stalls the scan indefinitely; index is unchanged.
- Index counter is `SEL_W` bits and never wraps within a sweep, since the `N`-1 check precedes increment.
- Channel inputs are treated as synchronous to `clk`; no synchronisers are included.

## Structure
- Shared package `mux_ent_pkg` holds:
  - state enum `mux_ent_state_t` (`IDLE`, `SCAN`, `DONE`);
  - localparam for the default `N`/`W`/`SEL_W`;
  - a function computing the minimum `SEL_W` from `N`, used for the elaboration check.
- One sub-module, `mux_ent_sel`: combinational, parametrised N:1 selector with an in-range flag; zero output when out of range. It is shared by the direct and scan paths through a 2:1 index select ahead of it.
- An elaboration-time check rejects 2^`SEL_W` < `N`.

## Test plan
- Reset, then direct read: ch5 = 8'h37, `sel` = 5, `r_s` pulse at t → at t+1: `sal` = 8'h37, `sal_idx` = 5, `sal_valid` = 1 for one cycle, `err` = 0.
- Out of range: `sel` = 4'hD, `r_s` = 1 → `sal` = 8'h00, `sal_valid` = 1, `err` = 1 for one cycle.
- Full scan with `ready` = 1 and ch[i] = 8'h10+i: 13 consecutive beats 8'h10..8'h1C with `sal_idx` 0..12 → `done` pulse at t+14, `busy` low after.
- Scan with `ready` low for 3 cycles on index 4 → `sal_idx` held at 4 and `sal` holds 8'h14 for those cycles; no skipped or duplicated index over the sweep.
- `r_s` during scan at index 7 → `err` = 1 for one cycle, scan continues to `done` unchanged.
- `reset` asserted at index 9 of a scan → next cycle all outputs = 0, state `IDLE`, no `done`; a fresh `scan_start` restarts at index 0.
